pmp_sel_dispatch: RTL and testbench
===================================

Name: pmp_sel_dispatch

Overview:
- Clocked, parametrised successor of the 3-way PMP selector.
- Accepts one upstream drive pulse with an N-bit channel-valid mask and drives the selected downstream channels after a programmable delay.
- Tracks which channels have returned free and pulses upstream free only when the join condition is met.
- Sits between the PMP check stage and the per-channel consumers in the MMU path.

Parameters:
- N_CH, 3, number of downstream channels (>=1).
- DRIVE_DLY, 1, cycles from accepted i_drive to o_drive_next pulse (>=1).
- MODE, 0, 0 = multicast (all set mask bits driven); 1 = priority (lowest set bit only).
- JOIN_ALL, 1, 1 = free upstream when all driven channels have freed; 0 = free on first driven channel's free.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- i_drive  in  1  upstream request, one-cycle pulse.
- i_data  in  N_CH  channel-valid mask, sampled with i_drive.
- o_free  out  1  upstream completion, one-cycle pulse.
- o_drive_next  out  N_CH  per-channel drive, one-cycle pulse.
- i_free_next  in  N_CH  per-channel completion pulses.
- o_busy  out  1  high from accept until o_free cycle (exclusive).
- o_err  out  1  one-cycle pulse: i_drive received while busy.

Behaviour:
- Reset: state IDLE; o_free, o_drive_next, o_busy, o_err = 0; mask, pending and delay counter cleared. Reset mid-transaction aborts it silently; no o_free is issued.
- States: IDLE, DELAY, WAIT, DONE.
- IDLE, i_drive=1:
  - Capture the filtered mask: MODE 0 = i_data; MODE 1 = lowest set bit of i_data.
  - Mask == 0: go to DONE (no channel driven).
  - Mask != 0: load counter = DRIVE_DLY-1 and go to DELAY.
- DELAY: counter decrements each cycle. In the cycle the counter is 0:
  - o_drive_next = mask.
  - pending = mask.
  - Go to WAIT.
  - Result: o_drive_next pulses exactly DRIVE_DLY cycles after the accept cycle.
- WAIT:
  - Each cycle, pending &= ~i_free_next.
  - i_free_next bits outside pending are ignored.
  - Frees are counted only from the cycle after the o_drive_next pulse; frees in or before that cycle are ignored.
  - JOIN_ALL=1: when the next value of pending is 0, go to DONE.
  - JOIN_ALL=0: when any pending bit clears, go to DONE; later frees for this transaction are ignored.
  - Multiple simultaneous frees are all applied in the same cycle.
- DONE:
  - o_free=1 for one cycle, o_busy=0, return to IDLE.
  - An i_drive in the DONE cycle is accepted as a new transaction (back-to-back, no bubble).
  - An empty-mask drive therefore frees 1 cycle after accept.
- o_busy is high in DELAY and WAIT, and high in the accept cycle's next state onward.
- Any i_drive while in DELAY or WAIT:
  - Ignored (no capture, no state change).
  - o_err pulses the following cycle.
- Upstream latency: at least DRIVE_DLY + 2 cycles for a non-empty mask (accept, drive pulse, free sample, DONE).
- Counter width: $clog2(DRIVE_DLY+1). No wrap-around is possible, because the counter only counts down from a loaded value.
- All outputs are registered.

Decomposition:
- Package pmp_sel_pkg:
  - state enum (IDLE, DELAY, WAIT, DONE).
  - MODE_MULTICAST/MODE_PRIORITY constants.
  - JOIN_ANY/JOIN_ALL constants.
- Sub-module pmp_sel_mask: combinational mode filter (pass-through, or lowest-set-bit isolate via x & -x), parametrised on N_CH and MODE.
- FSM, counter and pending register stay in the top module.

Test Plan:
- N_CH=3, DRIVE_DLY=1, MODE=0, JOIN_ALL=1: i_drive with i_data=3'b101 at cycle 0.
  - Expect o_drive_next=3'b101 at cycle 1.
  - Drive i_free_next=3'b001 at cycle 3 and 3'b100 at cycle 5; expect o_free at cycle 6.
- MODE=1, i_data=3'b110: expect o_drive_next=3'b010 only; i_free_next[1] at cycle 2 gives o_free at cycle 3.
- DRIVE_DLY=4, i_data=3'b001 at cycle 0: o_drive_next[0] at cycle 4 exactly; o_busy high cycles 1–(o_free-1).
- i_data=3'b000: no o_drive_next; o_free at cycle 1.
- JOIN_ALL=0, mask 3'b111: i_free_next=3'b010 at cycle 3 gives o_free at cycle 4; later frees on ch0/ch2 cause no extra o_free.
- Second i_drive at cycle 2 while busy gives o_err at cycle 3 with the transaction unchanged; new i_drive in the o_free cycle is accepted. Assert rst during WAIT: all outputs 0 next edge, no o_free afterwards.

Source files
------------

// File: rtl/pmp_sel_pkg.sv
// Shared types and constants for the PMP select/dispatch block.
package pmp_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Channel selection mode
  localparam int unsigned MODE_MULTICAST = 0;
  localparam int unsigned MODE_PRIORITY  = 1;

  // Upstream join condition
  localparam int unsigned JOIN_ANY = 0;
  localparam int unsigned JOIN_ALL = 1;

endpackage

// File: rtl/pmp_sel_mask.sv
// Channel-valid mask filter: pass-through (multicast) or lowest-set-bit isolate (priority).
module pmp_sel_mask
  import pmp_sel_pkg::*;
#(
  parameter int unsigned N_CH = 3,
  parameter int unsigned MODE = MODE_MULTICAST
) (
  input  logic [N_CH-1:0] i_data,
  output logic [N_CH-1:0] o_mask
);

  logic [N_CH-1:0] neg_data;

  // Two's complement AND isolates the lowest set bit (x & -x)
  always_comb begin
    neg_data = ~i_data + N_CH'(1);
    if (MODE == MODE_PRIORITY) begin
      o_mask = i_data & neg_data;
    end else begin
      o_mask = i_data;
    end
  end

endmodule

// File: rtl/pmp_sel_dispatch.sv
// PMP select/dispatch: accepts one upstream drive, pulses the selected downstream
// channels after DRIVE_DLY cycles, then joins their frees into one upstream free.
module pmp_sel_dispatch
  import pmp_sel_pkg::*;
#(
  parameter int unsigned N_CH      = 3,
  parameter int unsigned DRIVE_DLY = 1,
  parameter int unsigned MODE      = 0,
  parameter int unsigned JOIN_ALL  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_drive,
  input  logic [N_CH-1:0] i_data,
  output logic            o_free,
  output logic [N_CH-1:0] o_drive_next,
  input  logic [N_CH-1:0] i_free_next,
  output logic            o_busy,
  output logic            o_err
);

  localparam int unsigned CW = $clog2(DRIVE_DLY + 1);

  state_e          state_q, state_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] pend_nx;
  logic [N_CH-1:0] filt_mask;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0] drv_q, drv_d;
  logic            free_q, free_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  pmp_sel_mask #(
    .N_CH (N_CH),
    .MODE (MODE)
  ) u_mask (
    .i_data (i_data),
    .o_mask (filt_mask)
  );

  // Next-state logic; outputs are decoded from the next state so they leave a register
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    pend_nx = pend_q & ~i_free_next;

    unique case (state_q)
      IDLE, DONE: begin
        if (i_drive) begin
          mask_d = filt_mask;
          if (filt_mask == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = CW'(DRIVE_DLY - 1);
            state_d = DELAY;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        err_d = i_drive;
        if (cnt_q == '0) begin
          pend_d  = mask_q;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        err_d  = i_drive;
        pend_d = pend_nx;
        if (JOIN_ALL != JOIN_ANY) begin
          if (pend_nx == '0) state_d = DONE;
        end else if (pend_nx != pend_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Drive pulse is the cycle the counter sits at zero in DELAY
    drv_d  = (state_d == DELAY && cnt_d == '0) ? mask_d : '0;
    free_d = (state_d == DONE);
    busy_d = (state_d == DELAY) || (state_d == WAIT);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      free_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      free_q  <= free_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_free       = free_q;
  assign o_drive_next = drv_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_pmp_sel_dispatch.sv
// Directed bench for pmp_sel_dispatch across four parameter configurations.
module tb_pmp_sel_dispatch;

  logic       clk;
  logic       rst;
  logic       drv_i   [4];
  logic [2:0] data_i  [4];
  logic [2:0] fnext_i [4];
  logic       free_o  [4];
  logic [2:0] dn_o    [4];
  logic       busy_o  [4];
  logic       err_o   [4];

  int n_cmp;
  int n_bad;

  // 0: multicast, delay 1, join all
  pmp_sel_dispatch #(.N_CH(3), .DRIVE_DLY(1), .MODE(0), .JOIN_ALL(1)) u_dut0 (
    .clk(clk), .rst(rst), .i_drive(drv_i[0]), .i_data(data_i[0]), .o_free(free_o[0]),
    .o_drive_next(dn_o[0]), .i_free_next(fnext_i[0]), .o_busy(busy_o[0]), .o_err(err_o[0]));
  // 1: priority, delay 1, join all
  pmp_sel_dispatch #(.N_CH(3), .DRIVE_DLY(1), .MODE(1), .JOIN_ALL(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_drive(drv_i[1]), .i_data(data_i[1]), .o_free(free_o[1]),
    .o_drive_next(dn_o[1]), .i_free_next(fnext_i[1]), .o_busy(busy_o[1]), .o_err(err_o[1]));
  // 2: multicast, delay 4, join all
  pmp_sel_dispatch #(.N_CH(3), .DRIVE_DLY(4), .MODE(0), .JOIN_ALL(1)) u_dut2 (
    .clk(clk), .rst(rst), .i_drive(drv_i[2]), .i_data(data_i[2]), .o_free(free_o[2]),
    .o_drive_next(dn_o[2]), .i_free_next(fnext_i[2]), .o_busy(busy_o[2]), .o_err(err_o[2]));
  // 3: multicast, delay 1, join any
  pmp_sel_dispatch #(.N_CH(3), .DRIVE_DLY(1), .MODE(0), .JOIN_ALL(0)) u_dut3 (
    .clk(clk), .rst(rst), .i_drive(drv_i[3]), .i_data(data_i[3]), .o_free(free_o[3]),
    .o_drive_next(dn_o[3]), .i_free_next(fnext_i[3]), .o_busy(busy_o[3]), .o_err(err_o[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle to DUT k; returns #1 after the sampling edge
  task automatic step(input int k, input logic d, input logic [2:0] dat, input logic [2:0] fr);
    drv_i[k]   = d;
    data_i[k]  = dat;
    fnext_i[k] = fr;
    @(posedge clk);
    #1;
    drv_i[k]   = 1'b0;
    data_i[k]  = '0;
    fnext_i[k] = '0;
  endtask

  task automatic expect_out(input int k, input string tag, input logic fr, input logic [2:0] dn,
                            input logic bz, input logic er);
    check_eq({tag, ".free"}, 32'(free_o[k]), 32'(fr));
    check_eq({tag, ".drive"}, 32'(dn_o[k]), 32'(dn));
    check_eq({tag, ".busy"}, 32'(busy_o[k]), 32'(bz));
    check_eq({tag, ".err"}, 32'(err_o[k]), 32'(er));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv_i[k]   = 1'b0;
      data_i[k]  = '0;
      fnext_i[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) expect_out(k, "reset", 1'b0, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;

    // Multicast 101; free during drive cycle and on an undriven channel are ignored
    step(0, 1'b1, 3'b101, 3'b000); expect_out(0, "mc.c1", 1'b0, 3'b101, 1'b1, 1'b0);
    step(0, 1'b0, 3'b000, 3'b101); expect_out(0, "mc.c2", 1'b0, 3'b000, 1'b1, 1'b0);
    step(0, 1'b0, 3'b000, 3'b000); expect_out(0, "mc.c3", 1'b0, 3'b000, 1'b1, 1'b0);
    step(0, 1'b0, 3'b000, 3'b001); expect_out(0, "mc.c4", 1'b0, 3'b000, 1'b1, 1'b0);
    step(0, 1'b0, 3'b000, 3'b010); expect_out(0, "mc.c5", 1'b0, 3'b000, 1'b1, 1'b0);
    step(0, 1'b0, 3'b000, 3'b100); expect_out(0, "mc.c6", 1'b1, 3'b000, 1'b0, 1'b0);
    step(0, 1'b0, 3'b000, 3'b000); expect_out(0, "mc.c7", 1'b0, 3'b000, 1'b0, 1'b0);

    // Priority mode keeps only the lowest set bit
    step(1, 1'b1, 3'b110, 3'b000); expect_out(1, "pri.c1", 1'b0, 3'b010, 1'b1, 1'b0);
    step(1, 1'b0, 3'b000, 3'b000); expect_out(1, "pri.c2", 1'b0, 3'b000, 1'b1, 1'b0);
    step(1, 1'b0, 3'b000, 3'b010); expect_out(1, "pri.c3", 1'b1, 3'b000, 1'b0, 1'b0);
    step(1, 1'b0, 3'b000, 3'b000); expect_out(1, "pri.c4", 1'b0, 3'b000, 1'b0, 1'b0);

    // Delay of 4: drive lands exactly at cycle 4
    step(2, 1'b1, 3'b001, 3'b000); expect_out(2, "dly.c1", 1'b0, 3'b000, 1'b1, 1'b0);
    step(2, 1'b0, 3'b000, 3'b000); expect_out(2, "dly.c2", 1'b0, 3'b000, 1'b1, 1'b0);
    step(2, 1'b0, 3'b000, 3'b000); expect_out(2, "dly.c3", 1'b0, 3'b000, 1'b1, 1'b0);
    step(2, 1'b0, 3'b000, 3'b000); expect_out(2, "dly.c4", 1'b0, 3'b001, 1'b1, 1'b0);
    step(2, 1'b0, 3'b000, 3'b000); expect_out(2, "dly.c5", 1'b0, 3'b000, 1'b1, 1'b0);
    step(2, 1'b0, 3'b000, 3'b001); expect_out(2, "dly.c6", 1'b1, 3'b000, 1'b0, 1'b0);

    // Empty mask frees one cycle after accept with no drive
    step(0, 1'b1, 3'b000, 3'b000); expect_out(0, "empty.c1", 1'b1, 3'b000, 1'b0, 1'b0);
    step(0, 1'b0, 3'b000, 3'b000); expect_out(0, "empty.c2", 1'b0, 3'b000, 1'b0, 1'b0);

    // Join-any: first free completes, later frees do nothing
    step(3, 1'b1, 3'b111, 3'b000); expect_out(3, "any.c1", 1'b0, 3'b111, 1'b1, 1'b0);
    step(3, 1'b0, 3'b000, 3'b000); expect_out(3, "any.c2", 1'b0, 3'b000, 1'b1, 1'b0);
    step(3, 1'b0, 3'b000, 3'b000); expect_out(3, "any.c3", 1'b0, 3'b000, 1'b1, 1'b0);
    step(3, 1'b0, 3'b000, 3'b010); expect_out(3, "any.c4", 1'b1, 3'b000, 1'b0, 1'b0);
    step(3, 1'b0, 3'b000, 3'b001); expect_out(3, "any.c5", 1'b0, 3'b000, 1'b0, 1'b0);
    step(3, 1'b0, 3'b000, 3'b100); expect_out(3, "any.c6", 1'b0, 3'b000, 1'b0, 1'b0);

    // Drive while busy errors; drive in the free cycle is accepted back-to-back
    step(0, 1'b1, 3'b011, 3'b000); expect_out(0, "err.c1", 1'b0, 3'b011, 1'b1, 1'b0);
    step(0, 1'b0, 3'b000, 3'b000); expect_out(0, "err.c2", 1'b0, 3'b000, 1'b1, 1'b0);
    step(0, 1'b1, 3'b100, 3'b000); expect_out(0, "err.c3", 1'b0, 3'b000, 1'b1, 1'b1);
    step(0, 1'b0, 3'b000, 3'b011); expect_out(0, "err.c4", 1'b1, 3'b000, 1'b0, 1'b0);
    step(0, 1'b1, 3'b100, 3'b000); expect_out(0, "b2b.c5", 1'b0, 3'b100, 1'b1, 1'b0);
    step(0, 1'b0, 3'b000, 3'b000); expect_out(0, "b2b.c6", 1'b0, 3'b000, 1'b1, 1'b0);

    // Reset in WAIT aborts silently
    rst = 1'b1;
    #1;
    expect_out(0, "rst.async", 1'b0, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_out(0, "rst.edge", 1'b0, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    step(0, 1'b0, 3'b000, 3'b100); expect_out(0, "rst.p1", 1'b0, 3'b000, 1'b0, 1'b0);
    step(0, 1'b0, 3'b000, 3'b000); expect_out(0, "rst.p2", 1'b0, 3'b000, 1'b0, 1'b0);
    step(0, 1'b0, 3'b000, 3'b000); expect_out(0, "rst.p3", 1'b0, 3'b000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
